// File: rtl/cnff_count_ctrl.sv
// Controller that drives a bank of resetless cnff cells (hold / toggle / clear)
// as a modulo-(limit+1) up-counter started by valid/ready count commands.
module cnff_count_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             tick_en,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] n_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] inc_mask_s;
  logic             term_s;

  // Terminal tick: clearing here means all-ones never rolls over to zero.
  assign term_s = tick_en && (q_in == limit_q);

  // Ripple-carry enable: bit i toggles when all lower bits are 1.
  always_comb begin : inc_mask_p
    logic carry;
    carry      = 1'b1;
    inc_mask_s = ALL_ZEROS;
    for (int i = 0; i < WIDTH; i++) begin
      inc_mask_s[i] = carry;
      carry         = carry & q_in[i];
    end
  end

  // State, latched limit and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      limit_q <= ALL_ZEROS;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; abort outranks terminal detection.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    done_d  = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          limit_d = cmd_limit;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (term_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Bank control patterns and handshake outputs; unknown states clear the bank.
  always_comb begin
    c_out     = ALL_ZEROS;
    n_out     = ALL_ZEROS;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_INIT: begin
        n_out = ALL_ONES;
      end
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          n_out = ALL_ONES;
        end else begin
          n_out = ALL_ZEROS;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort || term_s) begin
          n_out = ALL_ONES;
        end else if (tick_en) begin
          n_out = inc_mask_s;
          c_out = inc_mask_s;
        end else begin
          n_out = ALL_ZEROS;
        end
      end
      default: begin
        n_out = ALL_ONES;
      end
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_cnff_count_ctrl.sv
// Bench for cnff_count_ctrl: models the cnff bank and checks the count
// against directed scenarios and an arithmetic reference model.
module tb_cnff_count_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_limit = 8'h00;
  logic       tick_en = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] c_out, n_out;
  logic       busy, done;

  logic [7:0] bank = 8'hA5;
  logic       load_en = 1'b0;
  logic [7:0] load_val = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit m_init = 1'b1;
  bit m_run  = 1'b0;
  bit m_done = 1'b0;
  int m_cnt  = 0;
  int m_limit = 0;

  cnff_count_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_limit(cmd_limit), .tick_en(tick_en), .abort(abort), .q_in(bank),
    .c_out(c_out), .n_out(n_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // cnff cell bank: hold on n=0, toggle on n=1,c=1, clear on n=1,c=0
  always @(posedge clk) begin
    if (load_en) bank <= load_val;
    else for (int i = 0; i < 8; i++)
      if (n_out[i]) bank[i] <= c_out[i] ? ~bank[i] : 1'b0;
  end

  // Advance the reference model by one edge from current inputs, then clock.
  task automatic step();
    if (!rst_n) begin
      m_init = 1; m_run = 0; m_cnt = 0; m_done = 0;
    end else if (m_init) begin
      m_init = 0; m_cnt = 0; m_done = 0;
    end else if (!m_run) begin
      m_done = 0;
      if (cmd_valid) begin m_run = 1; m_cnt = 0; m_limit = int'(cmd_limit); end
    end else begin
      m_done = 0;
      if (abort) begin
        m_run = 0; m_cnt = 0;
      end else if (tick_en) begin
        if (m_cnt == m_limit) begin m_run = 0; m_cnt = 0; m_done = 1; end
        else m_cnt = (m_cnt + 1) % 256;
      end
    end
    if (load_en) m_cnt = int'(load_val);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (n_out !== 8'hFF || c_out !== 8'h00) begin n_err++;
      $display("FAIL reset_pattern n_out=%h c_out=%h expected FF/00", n_out, c_out); end
    n_cmp++; if ({busy, cmd_ready, done} !== 3'b000) begin n_err++;
      $display("FAIL reset_outputs busy/ready/done=%b expected 000", {busy, cmd_ready, done}); end
    step();
    n_cmp++; if (bank !== 8'h00) begin n_err++;
      $display("FAIL reset_clear bank=%h expected 00", bank); end
    step();
    rst_n = 1'b1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++;
      $display("FAIL ready_before_init cmd_ready=%b expected 0", cmd_ready); end
    step();
    n_cmp++; if (cmd_ready !== 1'b1 || bank !== 8'h00) begin n_err++;
      $display("FAIL ready_after_init cmd_ready=%b bank=%h expected 1/00", cmd_ready, bank); end
  endtask

  task automatic test_count5();
    int exp5[6] = '{1, 2, 3, 4, 5, 0};
    int busy_cnt, done_cnt;
    cmd_limit = 8'd5; cmd_valid = 1'b1; tick_en = 1'b1;
    step();
    cmd_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || bank !== 8'h00) begin n_err++;
      $display("FAIL count5_accept busy=%b bank=%h expected 1/00", busy, bank); end
    busy_cnt = 1; done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      n_cmp++; if (bank !== 8'(exp5[k])) begin n_err++;
        $display("FAIL count5_bank step=%0d bank=%0d expected %0d", k, bank, exp5[k]); end
      n_cmp++; if (done !== (k == 5)) begin n_err++;
        $display("FAIL count5_done step=%0d done=%b expected %b", k, done, k == 5); end
    end
    tick_en = 1'b0;
    step();
    if (done) done_cnt++;
    n_cmp++; if (busy_cnt != 6) begin n_err++;
      $display("FAIL count5_busy_len got %0d cycles expected 6", busy_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_err++;
      $display("FAIL count5_done_len got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_pattern3();
    bit pat[7]  = '{1, 0, 0, 1, 1, 0, 1};
    int exp3[7] = '{1, 1, 1, 2, 3, 3, 0};
    cmd_limit = 8'd3; cmd_valid = 1'b1; tick_en = 1'b0;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick_en = pat[k];
      step();
      n_cmp++; if (bank !== 8'(exp3[k])) begin n_err++;
        $display("FAIL pattern3_bank step=%0d bank=%0d expected %0d", k, bank, exp3[k]); end
      n_cmp++; if (done !== (k == 6)) begin n_err++;
        $display("FAIL pattern3_done step=%0d done=%b expected %b", k, done, k == 6); end
    end
    tick_en = 1'b0;
    step();
  endtask

  task automatic test_full();
    cmd_limit = 8'hFF; cmd_valid = 1'b1; tick_en = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      if (k == 128) begin
        n_cmp++; if (bank !== 8'h7F || n_out !== 8'hFF || c_out !== 8'hFF) begin n_err++;
          $display("FAIL full_inc7f bank=%h n_out=%h c_out=%h expected 7F/FF/FF", bank, n_out, c_out); end
      end
      step();
      n_cmp++; if (bank !== 8'(k % 256) || done !== (k == 256) || busy !== (k != 256)) begin n_err++;
        $display("FAIL full_step k=%0d bank=%h done=%b busy=%b expected %h/%b/%b",
                 k, bank, done, busy, 8'(k % 256), k == 256, k != 256); end
    end
    tick_en = 1'b0;
    step();
  endtask

  task automatic test_abort();
    cmd_limit = 8'd10; cmd_valid = 1'b1; tick_en = 1'b1;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    n_cmp++; if (bank !== 8'd3) begin n_err++;
      $display("FAIL abort_pre bank=%0d expected 3", bank); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++; if (bank !== 8'h00 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin n_err++;
      $display("FAIL abort_post bank=%h busy=%b ready=%b done=%b expected 00/0/1/0",
               bank, busy, cmd_ready, done); end
    tick_en = 1'b0;
    step();
    n_cmp++; if (done !== 1'b0 || bank !== 8'h00) begin n_err++;
      $display("FAIL abort_nodone done=%b bank=%h expected 0/00", done, bank); end
  endtask

  task automatic test_back_to_back();
    cmd_limit = 8'd0; cmd_valid = 1'b1; tick_en = 1'b0;
    step();
    cmd_limit = 8'd7;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++; if (busy !== 1'b1 || bank !== 8'h00 || done !== 1'b0) begin n_err++;
        $display("FAIL b2b_ignore cyc=%0d busy=%b bank=%h done=%b expected 1/00/0", k, busy, bank, done); end
    end
    tick_en = 1'b1;
    step();
    n_cmp++; if (done !== 1'b1 || cmd_ready !== 1'b1 || bank !== 8'h00) begin n_err++;
      $display("FAIL b2b_done done=%b ready=%b bank=%h expected 1/1/00", done, cmd_ready, bank); end
    step();
    cmd_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0 || bank !== 8'h00) begin n_err++;
      $display("FAIL b2b_accept busy=%b done=%b bank=%h expected 1/0/00", busy, done, bank); end
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++; if (bank !== 8'(k % 8) || done !== (k == 8)) begin n_err++;
        $display("FAIL b2b_second k=%0d bank=%0d done=%b expected %0d/%b", k, bank, done, k % 8, k == 8); end
    end
    tick_en = 1'b0;
    step();
  endtask

  task automatic test_corruption();
    cmd_limit = 8'd3; cmd_valid = 1'b1; tick_en = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    tick_en = 1'b0; load_en = 1'b1; load_val = 8'd250;
    step();
    load_en = 1'b0;
    n_cmp++; if (bank !== 8'd250 || busy !== 1'b1) begin n_err++;
      $display("FAIL corrupt_load bank=%0d busy=%b expected 250/1", bank, busy); end
    tick_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++; if (bank !== ((k == 10) ? 8'd0 : 8'((250 + k) % 256)) || done !== (k == 10)) begin n_err++;
        $display("FAIL corrupt_wrap k=%0d bank=%0d done=%b", k, bank, done); end
    end
    tick_en = 1'b0;
    step();
  endtask

  task automatic test_reset_midrun();
    cmd_limit = 8'd20; cmd_valid = 1'b1; tick_en = 1'b1;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b0 || n_out !== 8'hFF || c_out !== 8'h00) begin n_err++;
      $display("FAIL midrun_async busy=%b ready=%b n_out=%h c_out=%h expected 0/0/FF/00",
               busy, cmd_ready, n_out, c_out); end
    step();
    n_cmp++; if (bank !== 8'h00 || done !== 1'b0) begin n_err++;
      $display("FAIL midrun_clear bank=%h done=%b expected 00/0", bank, done); end
    rst_n = 1'b1; tick_en = 1'b0;
    step();
    n_cmp++; if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin n_err++;
      $display("FAIL midrun_recover ready=%b done=%b busy=%b expected 1/0/0", cmd_ready, done, busy); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      cmd_valid = ($urandom % 4) == 0;
      cmd_limit = (($urandom % 16) == 0) ? 8'($urandom % 256) : 8'($urandom % 8);
      tick_en   = ($urandom % 10) < 7;
      abort     = ($urandom % 20) == 0;
      step();
      n_cmp++; if (bank !== 8'(m_cnt)) begin n_err++;
        $display("FAIL rand_bank cyc=%0d bank=%0d expected %0d", k, bank, m_cnt); end
      n_cmp++; if (busy !== m_run || cmd_ready !== (!m_run && !m_init)) begin n_err++;
        $display("FAIL rand_state cyc=%0d busy=%b ready=%b expected %b/%b", k, busy, cmd_ready,
                 m_run, !m_run && !m_init); end
      n_cmp++; if (done !== m_done) begin n_err++;
        $display("FAIL rand_done cyc=%0d done=%b expected %b", k, done, m_done); end
    end
    cmd_valid = 1'b0; tick_en = 1'b0; abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count5();
    test_pattern3();
    test_full();
    test_abort();
    test_back_to_back();
    test_corruption();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
